dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the memory-side end of the CPU load/store request interface.
- Accepts one word request at a time from the CPU's load/store path over a valid/ready handshake.
- Applies a configurable wait-state latency, performs the byte-enabled read or write on internal word storage, and returns a response over a second valid/ready handshake.
- Replaces the zero-latency data memory when the core moves to stall-capable memory access.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit words of storage; legal word index 0..DEPTH_WORDS-1.
- LATENCY, 2, wait-state cycles between request acceptance and response; legal 0..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data.
- req_be_i  in  4  byte enables for a store; bit n selects wdata[8n+7:8n].
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  requester accepts the response.
- rsp_rdata_o  out  32  load data; 0 for stores and errors.
- rsp_err_o  out  1  request was misaligned or out of range.

Behaviour:
- Reset (async, while rst_i=1):
  - FSM goes to IDLE; wait counter = 0.
  - req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - Storage contents are not reset.
  - Reset mid-transaction abandons it: no write is committed if reset asserts before the commit edge.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i=1, latch we/addr/wdata/be at that edge (the acceptance edge, cycle T).
  - Next state is WAIT with counter=LATENCY, or goes straight to commit if LATENCY=0.
  - req_ready_o=0 in every state except IDLE.
- WAIT:
  - Counter decrements by 1 each cycle.
  - When counter reaches 1, the next edge is the commit edge: perform the access and go to RESP.
- Commit edge; response first visible in cycle T+1+LATENCY:
  - Word index = addr[31:2].
  - err = (addr[1:0]!=0) or (addr[31:2] >= DEPTH_WORDS).
  - Load, no err: rsp_rdata_o = mem[index] (full word; be ignored).
  - Store, no err: each byte n with be[n]=1 is written; other bytes unchanged; rsp_rdata_o=0.
  - Store with be=4'b0000: no change, err=0.
  - err=1: no storage access, rsp_rdata_o=0, rsp_err_o=1.
- RESP:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o are held stable until handshake.
  - On rsp_ready_i=1, next state is IDLE; rsp_valid_o, rsp_rdata_o and rsp_err_o clear to 0.
  - req_ready_o rises the cycle after the response handshake; there is no same-cycle new acceptance.
  - rsp_ready_i held low stalls indefinitely; request inputs are ignored while not in IDLE.
- Throughput: at most one request per (LATENCY+2) cycles.
- req_valid_i may deassert after acceptance without effect.

Test Plan:
- LATENCY=2: store addr=0x10, wdata=0xDEADBEEF, be=4'hF accepted at cycle T -> rsp_valid_o=1 at T+3, rsp_err_o=0, rsp_rdata_o=0. A subsequent load of 0x10 returns 0xDEADBEEF at acceptance+3.
- Byte enables: after the word is 0xDEADBEEF, store wdata=0x11223344 with be=4'b0101 -> next load returns 0xDE22BE44.
- Errors:
  - Load addr=0x12 -> rsp_err_o=1, rsp_rdata_o=0.
  - Store addr=0x200 (index 128 with DEPTH_WORDS=128) -> rsp_err_o=1 and no storage word changes.
- Backpressure: hold rsp_ready_i=0 for 5 cycles during RESP -> rsp_valid_o and rsp_rdata_o stay stable and req_ready_o stays 0. Release -> rsp_valid_o=0 and req_ready_o=1 on the following cycle.
- LATENCY=0: load accepted at T -> rsp_valid_o at T+1; back-to-back loads with rsp_ready_i=1 complete every 2 cycles.
- Reset mid-transaction: assert rst_i during WAIT of a store to 0x20 (old 0x0) -> outputs go immediately to reset values and a later load of 0x20 returns 0x0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bus between the CPU load/store path and the data-memory responder.
// Signal names follow the responder's point of view (_i into it, _o out of it).
interface dmem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport slave (
        input  req_valid_i,
        output req_ready_o,
        input  req_we_i,
        input  req_addr_i,
        input  req_wdata_i,
        input  req_be_i,
        output rsp_valid_o,
        input  rsp_ready_i,
        output rsp_rdata_o,
        output rsp_err_o
    );

    modport master (
        output req_valid_i,
        input  req_ready_o,
        output req_we_i,
        output req_addr_i,
        output req_wdata_i,
        output req_be_i,
        input  rsp_valid_o,
        output rsp_ready_i,
        input  rsp_rdata_o,
        input  rsp_err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, LATENCY wait states,
// byte-enabled word storage, response held until the requester takes it.
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);

    localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT     = 4'(LATENCY);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    // Access operands: with zero wait states the commit happens on the
    // acceptance edge, so the live request is used instead of the latched one.
    logic             commit;
    logic             c_we;
    logic [31:0]      c_addr;
    logic [31:0]      c_wdata;
    logic [3:0]       c_be;
    logic             c_err;
    logic [IDX_W-1:0] c_idx;
    logic [31:0]      rd_word;
    logic             wr_en;

    assign c_we    = (state_q == ST_IDLE) ? bus.req_we_i    : we_q;
    assign c_addr  = (state_q == ST_IDLE) ? bus.req_addr_i  : addr_q;
    assign c_wdata = (state_q == ST_IDLE) ? bus.req_wdata_i : wdata_q;
    assign c_be    = (state_q == ST_IDLE) ? bus.req_be_i    : be_q;
    assign c_idx   = c_addr[IDX_W+1:2];
    assign c_err   = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= DEPTH_W);
    assign rd_word = mem_q[c_idx];
    assign wr_en   = commit && c_we && !c_err && !rst_i;

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    we_d    = bus.req_we_i;
                    addr_d  = bus.req_addr_i;
                    wdata_d = bus.req_wdata_i;
                    be_d    = bus.req_be_i;
                    if (LAT == 4'd0) begin
                        commit  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = LAT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = ST_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit) begin
            err_d   = c_err;
            rdata_d = (!c_we && !c_err) ? rd_word : '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: storage is deliberately not reset; reset only blocks the commit via wr_en.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int n = 0; n < 4; n++) begin
                if (c_be[n]) begin
                    mem_q[c_idx][8*n +: 8] <= c_wdata[8*n +: 8];
                end
            end
        end
    end

    assign bus.req_ready_o = (state_q == ST_IDLE);
    assign bus.rsp_valid_o = (state_q == ST_RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;

endmodule
